// File: rtl/timer_pkg.sv
// Shared definitions for the countdown-timer control block: FSM state
// encoding and the range of keypad codes that load the datapath.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam logic [3:0] KEY_MIN = 4'd1;
  localparam logic [3:0] KEY_MAX = 4'd6;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises an active-low raw button and emits one press pulse once the
// button has read pressed for DEBOUNCE_MS consecutive 1 kHz ticks.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic raw_n,
  output logic press
);

  logic [1:0] sync_q;
  logic [4:0] cnt_q;

  // Synchroniser resets to the released level so reset release is quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
      cnt_q  <= 5'd0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_n};
      press  <= 1'b0;
      if (tick) begin
        if (sync_q[1]) begin
          cnt_q <= 5'd0;
        end else if (cnt_q != 5'(DEBOUNCE_MS)) begin
          cnt_q <= cnt_q + 5'd1;
          press <= (cnt_q == 5'(DEBOUNCE_MS - 1));
        end
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Control FSM for the countdown timer: debounced start/clear, keypad gating,
// start/clear pulses to the datapath and the alarm buzzer sequencing.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int ALARM_MS    = 3000,
  parameter int BEEP_MS     = 250
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_pls_1k,
  input  logic       i_btn_start_n,
  input  logic       i_btn_clear_n,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_data,
  input  logic       i_fin,
  output logic       o_start,
  output logic       o_clear,
  output logic       o_key_valid,
  output logic [3:0] o_key_data,
  output logic       o_buzz,
  output logic       o_blink,
  output logic [2:0] o_state
);

  state_t      state_q, state_d;
  logic        start_ev, clear_ev;
  logic        start_d, clear_d, key_ok, key_acc;
  logic        alarm_done;
  logic [11:0] alarm_cnt;
  logic [11:0] beep_cnt;
  logic        beep_off;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
    .clk(i_clk), .rstn(i_rstn), .tick(i_pls_1k), .raw_n(i_btn_start_n), .press(start_ev)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clear (
    .clk(i_clk), .rstn(i_rstn), .tick(i_pls_1k), .raw_n(i_btn_clear_n), .press(clear_ev)
  );

  assign key_ok     = i_key_valid && (i_key_data >= KEY_MIN) && (i_key_data <= KEY_MAX);
  assign alarm_done = (alarm_cnt == 12'(ALARM_MS));
  assign o_blink    = (state_q == ST_PAUSE);
  assign o_state    = state_q;

  // Priority inside each state: fin, then clear, then start, then keys.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    clear_d = 1'b0;
    key_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_ok) begin
          key_acc = 1'b1;
          state_d = ST_SET;
        end
      end
      ST_SET: begin
        if (clear_ev) begin
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ev) begin
          start_d = 1'b1;
          state_d = ST_RUN;
        end else if (key_ok) begin
          key_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_fin) begin
          state_d = ST_ALARM;
        end else if (clear_ev) begin
          start_d = 1'b1;
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ev) begin
          start_d = 1'b1;
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clear_ev) begin
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else if (start_ev) begin
          start_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        // Datapath stopped itself at zero; the start pulse re-syncs its run enable.
        if (start_ev || clear_ev || alarm_done) begin
          start_d = 1'b1;
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      o_start     <= 1'b0;
      o_clear     <= 1'b0;
      o_key_valid <= 1'b0;
      o_key_data  <= 4'd0;
    end else begin
      state_q     <= state_d;
      o_start     <= start_d;
      o_clear     <= clear_d;
      o_key_valid <= key_acc;
      if (key_acc) o_key_data <= i_key_data;
    end
  end

  // Alarm timers sit cleared whenever the FSM is not staying in ALARM.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      alarm_cnt <= 12'd0;
      beep_cnt  <= 12'd0;
      beep_off  <= 1'b0;
      o_buzz    <= 1'b0;
    end else if (state_q != ST_ALARM || state_d != ST_ALARM) begin
      alarm_cnt <= 12'd0;
      beep_cnt  <= 12'd0;
      beep_off  <= 1'b0;
      o_buzz    <= 1'b0;
    end else if (i_pls_1k) begin
      alarm_cnt <= alarm_cnt + 12'd1;
      if (!beep_off) o_buzz <= ~o_buzz;
      if (beep_cnt == 12'(BEEP_MS - 1)) begin
        beep_cnt <= 12'd0;
        beep_off <= ~beep_off;
      end else begin
        beep_cnt <= beep_cnt + 12'd1;
      end
    end
  end

endmodule
